// File: rtl/complex_acc_pkg.sv
// complex_acc_pkg: shared state encoding and accumulator width derivation for complex_acc.
`default_nettype none

package complex_acc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int MAX_LEN  = 16;
  localparam int GROWTH_W = $clog2(MAX_LEN);

  // Summing up to MAX_LEN products grows the magnitude by at most GROWTH_W bits.
  function automatic int acc_width(input int in_w);
    return in_w + GROWTH_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_acc.sv
// complex_acc: sums LEN complex products per frame; sof mid-frame aborts and restarts the frame.
`default_nettype none

module complex_acc
  import complex_acc_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int LEN   = 4,
  parameter int OUT_W = acc_width(IN_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    sof,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic signed [OUT_W-1:0] acc_real,
  output logic signed [OUT_W-1:0] acc_imag,
  output logic                    acc_valid,
  output logic                    frame_abort,
  output logic                    busy
);

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [OUT_W-1:0] sum_real_q, sum_real_d;
  logic signed [OUT_W-1:0] sum_imag_q, sum_imag_d;
  logic signed [OUT_W-1:0] acc_real_q, acc_real_d;
  logic signed [OUT_W-1:0] acc_imag_q, acc_imag_d;
  logic                    acc_valid_q, acc_valid_d;
  logic                    abort_q, abort_d;

  logic signed [OUT_W-1:0] ext_real, ext_imag;
  logic signed [OUT_W-1:0] add_real, add_imag;
  logic                    last_sample;
  logic                    restart;

  assign ext_real    = OUT_W'(in_real);
  assign ext_imag    = OUT_W'(in_imag);
  assign add_real    = sum_real_q + ext_real;
  assign add_imag    = sum_imag_q + ext_imag;
  assign last_sample = (state_q == ACCUM) && !sof && (count_q == LAST_CNT);
  // Any sample taken in IDLE, or a sof in ACCUM, starts a fresh frame.
  assign restart     = (state_q == IDLE) || sof;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sum_real_q  <= '0;
      sum_imag_q  <= '0;
      acc_real_q  <= '0;
      acc_imag_q  <= '0;
      acc_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_real_q  <= sum_real_d;
      sum_imag_q  <= sum_imag_d;
      acc_real_q  <= acc_real_d;
      acc_imag_q  <= acc_imag_d;
      acc_valid_q <= acc_valid_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        IDLE:    state_d = ACCUM;
        ACCUM:   state_d = last_sample ? IDLE : ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d     = count_q;
    sum_real_d  = sum_real_q;
    sum_imag_d  = sum_imag_q;
    acc_real_d  = acc_real_q;
    acc_imag_d  = acc_imag_q;
    acc_valid_d = 1'b0;
    abort_d     = 1'b0;
    if (in_valid) begin
      if (restart) begin
        sum_real_d = ext_real;
        sum_imag_d = ext_imag;
        count_d    = CNT_W'(1);
        abort_d    = (state_q == ACCUM);
      end else if (last_sample) begin
        acc_real_d  = add_real;
        acc_imag_d  = add_imag;
        acc_valid_d = 1'b1;
        sum_real_d  = '0;
        sum_imag_d  = '0;
        count_d     = '0;
      end else begin
        sum_real_d = add_real;
        sum_imag_d = add_imag;
        count_d    = count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    busy        = (state_q == ACCUM);
    acc_real    = acc_real_q;
    acc_imag    = acc_imag_q;
    acc_valid   = acc_valid_q;
    frame_abort = abort_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_complex_acc.sv
// tb_complex_acc: scoreboard bench for complex_acc at LEN=4 and LEN=16.
`default_nettype none

module tb_complex_acc;

  typedef struct {
    int re;
    int im;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, sof;
  logic signed [15:0] in_real, in_imag;
  logic signed [19:0] acc_real, acc_imag;
  logic acc_valid, frame_abort, busy;

  logic v16, s16;
  logic signed [15:0] r16, i16;
  logic signed [19:0] acc_real16, acc_imag16;
  logic acc_valid16, frame_abort16, busy16;

  res_t exp_q[$];
  res_t got_q[$];
  int   pulse_t[$];
  int   cyc = 0;
  int   v_cnt = 0, a_cnt = 0, both_cnt = 0;
  int   checks = 0, errors = 0;

  complex_acc #(.IN_W(16), .LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
    .in_real(in_real), .in_imag(in_imag),
    .acc_real(acc_real), .acc_imag(acc_imag),
    .acc_valid(acc_valid), .frame_abort(frame_abort), .busy(busy)
  );

  complex_acc #(.IN_W(16), .LEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .sof(s16),
    .in_real(r16), .in_imag(i16),
    .acc_real(acc_real16), .acc_imag(acc_imag16),
    .acc_valid(acc_valid16), .frame_abort(frame_abort16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_valid) begin
      got_q.push_back('{int'(acc_real), int'(acc_imag)});
      pulse_t.push_back(cyc);
      v_cnt++;
    end
    if (frame_abort) a_cnt++;
    if (acc_valid && frame_abort) both_cnt++;
  end

  task automatic send(input int re, input int im, input bit s);
    in_valid = 1'b1;
    sof      = s;
    in_real  = 16'(re);
    in_imag  = 16'(im);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    sof      = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic get_result(output res_t g, output bit ok);
    for (int k = 0; k < 10 && got_q.size() == 0; k++) @(negedge clk);
    #1;
    ok = (got_q.size() != 0);
    if (ok) g = got_q.pop_front();
    else g = '{0, 0};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sof = 1'b0; in_real = '0; in_imag = '0;
    v16 = 1'b0; s16 = 1'b0; r16 = '0; i16 = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (acc_real !== 20'sd0 || acc_imag !== 20'sd0) begin
      errors++; $display("FAIL reset_acc got (%0d,%0d) want (0,0)", acc_real, acc_imag);
    end
    checks++;
    if (acc_valid !== 1'b0 || frame_abort !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got v=%b a=%b b=%b want 0 0 0", acc_valid, frame_abort, busy);
    end
    checks++;
    if (acc_real16 !== 20'sd0 || acc_valid16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL reset_len16 got acc=%0d v=%b b=%b want 0 0 0", acc_real16, acc_valid16, busy16);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_gaps();
    res_t g, e; bit ok; int v0;
    v0 = v_cnt;
    exp_q.push_back('{-44, 76});
    send(-5, 10, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy got %b want 1", busy); end
    idle(2); send(-20, 40, 1'b0);
    idle(2); send(-16, 22, 1'b0);
    idle(2);
    checks++;
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL gaps_early got acc_valid=%b want 0", acc_valid); end
    send(-3, 4, 1'b0);
    checks++;
    if (acc_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL gaps_latency got v=%b busy=%b want 1 0", acc_valid, busy);
    end
    get_result(g, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g.re != e.re || g.im != e.im) begin
      errors++; $display("FAIL gaps_sum got (%0d,%0d) ok=%b want (%0d,%0d)", g.re, g.im, ok, e.re, e.im);
    end
    idle(3);
    checks++;
    if (v_cnt - v0 != 1 || acc_real !== -20'sd44 || acc_imag !== 20'sd76) begin
      errors++; $display("FAIL gaps_hold got pulses=%0d acc=(%0d,%0d) want 1 (-44,76)", v_cnt - v0, acc_real, acc_imag);
    end
  endtask

  task automatic test_abort();
    res_t g, e; bit ok; int a0;
    a0 = a_cnt;
    exp_q.push_back('{-6, 41});
    send(-5, 10, 1'b0);
    send(-20, 40, 1'b0);
    send(-9, 38, 1'b1);
    checks++;
    if (frame_abort !== 1'b1 || acc_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pulse got a=%b v=%b busy=%b want 1 0 1", frame_abort, acc_valid, busy);
    end
    checks++;
    if (acc_real !== -20'sd44 || acc_imag !== 20'sd76) begin
      errors++; $display("FAIL abort_acc_hold got (%0d,%0d) want (-44,76)", acc_real, acc_imag);
    end
    idle(1);
    checks++;
    if (frame_abort !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", frame_abort); end
    send(1, 1, 1'b0); send(1, 1, 1'b0); send(1, 1, 1'b0);
    get_result(g, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g.re != e.re || g.im != e.im) begin
      errors++; $display("FAIL abort_sum got (%0d,%0d) ok=%b want (%0d,%0d)", g.re, g.im, ok, e.re, e.im);
    end
    checks++;
    if (a_cnt - a0 != 1) begin errors++; $display("FAIL abort_count got %0d want 1", a_cnt - a0); end
  endtask

  task automatic test_back_to_back();
    res_t g, e; bit ok; int t0;
    pulse_t.delete();
    exp_q.push_back('{4, 8});
    exp_q.push_back('{4, 8});
    in_valid = 1'b1; sof = 1'b0; in_real = 16'sd1; in_imag = 16'sd2;
    repeat (8) @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      get_result(g, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g.re != e.re || g.im != e.im) begin
        errors++; $display("FAIL b2b_sum%0d got (%0d,%0d) ok=%b want (%0d,%0d)", n, g.re, g.im, ok, e.re, e.im);
      end
    end
    checks++;
    t0 = (pulse_t.size() >= 2) ? pulse_t[1] - pulse_t[0] : -1;
    if (pulse_t.size() != 2 || t0 != 4) begin
      errors++; $display("FAIL b2b_spacing got pulses=%0d gap=%0d want 2 4", pulse_t.size(), t0);
    end
  endtask

  task automatic test_reset_mid();
    res_t g, e; bit ok; int a0, v0;
    a0 = a_cnt; v0 = v_cnt;
    send(2, 3, 1'b0); send(2, 3, 1'b0); send(2, 3, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_real = 16'sd7; in_imag = 16'sd7;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (acc_real !== 20'sd0 || acc_imag !== 20'sd0 || busy !== 1'b0 || acc_valid !== 1'b0 || frame_abort !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got acc=(%0d,%0d) b=%b v=%b a=%b want 0s", acc_real, acc_imag, busy, acc_valid, frame_abort);
    end
    idle(2);
    checks++;
    if (a_cnt != a0 || v_cnt != v0) begin
      errors++; $display("FAIL rstmid_pulses got abort=%0d valid=%0d want 0 0", a_cnt - a0, v_cnt - v0);
    end
    exp_q.push_back('{8, 12});
    repeat (4) send(2, 3, 1'b0);
    get_result(g, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g.re != e.re || g.im != e.im) begin
      errors++; $display("FAIL rstmid_sum got (%0d,%0d) ok=%b want (%0d,%0d)", g.re, g.im, ok, e.re, e.im);
    end
  endtask

  task automatic test_hold();
    res_t g, e; bit ok; int bad;
    logic signed [19:0] hr, hi;
    bad = 0;
    exp_q.push_back('{4, 4});
    send(1, 1, 1'b0); send(1, 1, 1'b0);
    hr = acc_real; hi = acc_imag;
    for (int n = 0; n < 20; n++) begin
      in_valid = 1'b0;
      sof      = 1'($urandom_range(0, 1));
      in_real  = 16'($urandom);
      in_imag  = 16'($urandom);
      @(posedge clk); #1;
      if (acc_real !== hr || acc_imag !== hi || busy !== 1'b1 || acc_valid !== 1'b0 || frame_abort !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    sof = 1'b0;
    send(1, 1, 1'b0);
    checks++;
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL hold_count got acc_valid=%b want 0", acc_valid); end
    send(1, 1, 1'b0);
    get_result(g, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || g.re != e.re || g.im != e.im) begin
      errors++; $display("FAIL hold_sum got (%0d,%0d) ok=%b want (%0d,%0d)", g.re, g.im, ok, e.re, e.im);
    end
  endtask

  task automatic test_len16();
    v16 = 1'b1; s16 = 1'b0; r16 = -16'sd32768; i16 = 16'sd32767;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (acc_valid16 !== 1'b0 || busy16 !== 1'b1) begin
      errors++; $display("FAIL len16_early got v=%b busy=%b want 0 1", acc_valid16, busy16);
    end
    @(posedge clk); #1;
    v16 = 1'b0;
    checks++;
    if (acc_valid16 !== 1'b1 || acc_real16 !== -20'sd524288 || acc_imag16 !== 20'sd524272) begin
      errors++; $display("FAIL len16_sum got v=%b (%0d,%0d) want 1 (-524288,524272)", acc_valid16, acc_real16, acc_imag16);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0 || exp_q.size() != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL exclusive got both=%0d exp_left=%0d got_left=%0d want 0 0 0", both_cnt, exp_q.size(), got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_len16();
    idle(3);
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/complex_acc.md
COMPLEX_ACC -- requirements
Module: complex_acc

Interface
REQ-001 Parameter IN_W, default 16, signed input component width (matches the complex multiplier z_real/z_imag outputs).
REQ-002 Parameter LEN, default 4, number of complex products summed per frame; legal range 2..16.
REQ-003 Parameter OUT_W, default IN_W+4, signed accumulator/output component width.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_real/in_imag carry a valid product this cycle.
REQ-007 sof  input  1  start of frame; qualified by in_valid; marks the current sample as frame sample 0.
REQ-008 in_real  input  IN_W  signed real part of the product.
REQ-009 in_imag  input  IN_W  signed imaginary part of the product.
REQ-010 acc_real  output  OUT_W  signed real sum of the last completed frame, registered.
REQ-011 acc_imag  output  OUT_W  signed imaginary sum of the last completed frame, registered.
REQ-012 acc_valid  output  1  one-cycle pulse; acc_real/acc_imag hold a new frame sum.
REQ-013 frame_abort  output  1  one-cycle pulse; a partial frame was discarded.
REQ-014 busy  output  1  high while a frame is partially accumulated (state ACCUM).

Function
REQ-015 States: IDLE (no samples held) and ACCUM (1..LEN-1 samples held); count register 0..LEN-1.
REQ-016 IDLE, in_valid=1 (sof ignored): running sums <= sign-extended sample, count <= 1, go to ACCUM.
REQ-017 ACCUM, in_valid=1, sof=0, count<LEN-1: running sums += sign-extended sample, count += 1.
REQ-018 ACCUM, in_valid=1, sof=0, count=LEN-1: acc_real/acc_imag <= running sum + sample, acc_valid=1 next cycle, count <= 0, go to IDLE.
REQ-019 ACCUM, in_valid=1, sof=1: frame_abort=1 next cycle, partial sums discarded, sample loaded as new frame sample 0, count <= 1, stay ACCUM; acc_* unchanged.
REQ-020 in_valid=0: no change to sums, count or state; gaps of any length are allowed within a frame.
REQ-021 Latency: acc_valid asserts on the cycle immediately after the edge that captures the LEN-th sample.
REQ-022 acc_real/acc_imag hold their value between acc_valid pulses.
REQ-023 Arithmetic is two's complement, sign-extended to OUT_W; no overflow for LEN<=16, so no saturation logic.
REQ-024 acc_valid and frame_abort never assert in the same cycle, and each is high for exactly one cycle per event.
REQ-025 Back-to-back frames with in_valid held high are accepted at one sample per clock with no bubble.

Reset
REQ-026 rst=1 at a rising edge: state IDLE, count 0, running sums 0, acc_real 0, acc_imag 0, acc_valid 0, frame_abort 0, busy 0.
REQ-027 rst mid-frame discards the partial frame without asserting frame_abort; rst takes priority over in_valid.

Structure
REQ-028 A shared package holds the state enumeration (IDLE, ACCUM) and the OUT_W derivation (IN_W + clog2(16)).
REQ-029 The block is implemented as a single module with no sub-modules; the FSM, counter and two adders are inline.

Verification
REQ-030 LEN=4; four pulses in_valid=1 with gaps of 2 idle cycles, products (-5,10),(-20,40),(-16,22),(-3,4) -> single acc_valid pulse with acc=(-44,76) one cycle after the 4th sample.
REQ-031 In ACCUM after 2 samples (-5,10),(-20,40), sof=1 with (-9,38) -> frame_abort pulse; next 3 samples (1,1),(1,1),(1,1) -> acc=(-6,41).
REQ-032 8 consecutive cycles of in_valid=1 with (1,2) -> acc_valid pulses 4 cycles apart, each with acc=(4,8).
REQ-033 LEN=16; 16 samples (-32768,32767) -> acc=(-524288,524272), no wrap.
REQ-034 rst=1 after 3 samples -> all outputs 0, no acc_valid or frame_abort; next 4 samples (2,3) -> acc=(8,12).
REQ-035 in_valid=0 with random in_real/in_imag for 20 cycles -> no state change, acc_* stable, busy stable.
